// File: rtl/hdr_entry_sequencer_pkg.sv
// Shared definitions for the HDR entry sequencer and its helpers.
//   - sequencer state encoding and debug struct
//   - descriptor field positions, mode / CCC constants, error codes
//   - register-file base address and watchdog limit
package hdr_entry_sequencer_pkg;

  localparam logic [11:0] CONFIG_BASE = 12'd1000;
  localparam int          TIMEOUT_CYC = 4096;
  localparam int          WDOG_W      = 13;

  localparam logic [2:0]  MODE_HDR_DDR = 3'd6;
  localparam logic [7:0]  ENTHDR0      = 8'h20;

  localparam logic [1:0]  ERR_NONE    = 2'b00;
  localparam logic [1:0]  ERR_MODE    = 2'b01;
  localparam logic [1:0]  ERR_NACK    = 2'b10;
  localparam logic [1:0]  ERR_TIMEOUT = 2'b11;

  // Descriptor byte 3 = {TOC, WROC, RnW, MODE[2:0], DTT[2:1]}; byte 1 bit 7 = CP.
  localparam int B3_TOC      = 7;
  localparam int B3_WROC     = 6;
  localparam int B3_RNW      = 5;
  localparam int B3_MODE_LSB = 2;
  localparam int B3_DTT_LSB  = 0;
  localparam int B1_CP       = 7;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_SDR     = 4'd3,
    ST_DDR     = 4'd4,
    ST_EXIT    = 4'd5,
    ST_DONE    = 4'd6,
    ST_ERR     = 4'd7,
    ST_RELEASE = 4'd8
  } seq_state_t;

  // Debug view of the FSM and the latched descriptor fields.
  typedef struct packed {
    seq_state_t state;
    logic       cp;
    logic       toc;
    logic       wroc;
    logic       rnw;
    logic [2:0] mode;
    logic [1:0] dtt;
  } seq_dbg_t;

  function automatic logic [2:0] desc_mode(input logic [7:0] b3);
    return b3[B3_MODE_LSB +: 3];
  endfunction

endpackage

// File: rtl/hdr_entry_sequencer_watchdog.sv
// seq_watchdog: cycle counter for wait-for-done states.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clear      : zero the counter (asserted on the edge entering a wait state)
//   i_en         : count while in a wait state
//   i_limit      : terminal count; o_expired is high while the count equals it
// o_expired is combinational from the count so the owner can act in the same
// cycle; it does not depend on i_clear, which keeps the owner's loop acyclic.
module seq_watchdog #(
  parameter int W = 13
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clear,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic         o_expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      cnt <= '0;
    end else if (i_en && (cnt != i_limit)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_expired = i_en && (cnt == i_limit);

endmodule

// File: rtl/hdr_entry_sequencer.sv
// hdr_entry_sequencer: schedules HDR entry for the I3C controller.
// Fetches a 4-byte descriptor, checks MODE, runs the SDR engine (broadcast +
// ENTHDR0), hands the bus to the HDR-DDR engine and optionally to the exit
// pattern generator. Only one engine enable is ever high.
//
// Ports:
//   i_sdr_clk, i_sdr_rst        clock, synchronous active-high reset
//   i_seq_en                    start request (level), sampled in IDLE
//   o_regf_rd_en/o_regf_addr    register-file read strobe/address
//   i_regf_data                 read data, valid the cycle after the strobe
//   o_sdr_en/o_sdr_code         SDR engine enable and CCC code
//   i_sdr_done/i_sdr_nack       SDR completion pulse and NACK flag
//   o_ddr_en/i_ddr_done         HDR-DDR engine enable / done pulse
//   o_exit_en/i_exit_done       exit-pattern enable / done pulse
//   o_busy                      high outside IDLE
//   o_seq_done/o_seq_err        one-cycle outcome pulses
//   o_err_code                  error cause, held until the next start
//   o_dbg                       FSM state and latched descriptor fields
//
// Engine handshake: an engine runs while its enable is high and reports
// completion with a single-cycle done pulse. On the edge that samples the
// done, the enable drops and the next enable rises. Done pulses seen in any
// other state are ignored; i_sdr_nack is only looked at together with
// i_sdr_done.
//
// Every output is a register loaded from the next state, so outputs change on
// the same edge as the state.
module hdr_entry_sequencer
  import hdr_entry_sequencer_pkg::*;
(
  input  logic        i_sdr_clk,
  input  logic        i_sdr_rst,
  input  logic        i_seq_en,
  output logic        o_regf_rd_en,
  output logic [11:0] o_regf_addr,
  input  logic [7:0]  i_regf_data,
  output logic        o_sdr_en,
  output logic [7:0]  o_sdr_code,
  input  logic        i_sdr_done,
  input  logic        i_sdr_nack,
  output logic        o_ddr_en,
  input  logic        i_ddr_done,
  output logic        o_exit_en,
  input  logic        i_exit_done,
  output logic        o_busy,
  output logic        o_seq_done,
  output logic        o_seq_err,
  output logic [1:0]  o_err_code,
  output seq_dbg_t    o_dbg
);

  seq_state_t state, state_next;
  logic [2:0] fetch_cnt, fetch_cnt_next;
  logic [1:0] err_next;
  logic [7:0] desc_b3;
  logic       desc_cp;
  logic       wd_expired;
  logic       wd_en;

  logic        rd_en_d;
  logic [11:0] addr_d;
  logic        sdr_en_d;
  logic [7:0]  sdr_code_d;
  logic        ddr_en_d;
  logic        exit_en_d;
  logic        busy_d;
  logic        done_d;
  logic        err_d;

  assign wd_en = (state == ST_SDR) || (state == ST_DDR) || (state == ST_EXIT);

  // Clearing on every state change zeroes the count on the edge that enters
  // SDR, DDR or EXIT, so the first cycle in each wait state counts 0.
  seq_watchdog #(.W(WDOG_W)) u_watchdog (
    .i_clk     (i_sdr_clk),
    .i_rst     (i_sdr_rst),
    .i_clear   (state_next != state),
    .i_en      (wd_en),
    .i_limit   (WDOG_W'(TIMEOUT_CYC - 1)),
    .o_expired (wd_expired)
  );

  // State and output registers.
  always_ff @(posedge i_sdr_clk) begin
    if (i_sdr_rst) begin
      state        <= ST_IDLE;
      fetch_cnt    <= '0;
      desc_b3      <= '0;
      desc_cp      <= 1'b0;
      o_regf_rd_en <= 1'b0;
      o_regf_addr  <= '0;
      o_sdr_en     <= 1'b0;
      o_sdr_code   <= 8'h00;
      o_ddr_en     <= 1'b0;
      o_exit_en    <= 1'b0;
      o_busy       <= 1'b0;
      o_seq_done   <= 1'b0;
      o_seq_err    <= 1'b0;
      o_err_code   <= ERR_NONE;
    end else begin
      state        <= state_next;
      fetch_cnt    <= fetch_cnt_next;
      // Read k is strobed in FETCH cycle k, so its data lands in cycle k+1.
      if (state == ST_FETCH) begin
        if (fetch_cnt == 3'd2) desc_cp <= i_regf_data[B1_CP];
        if (fetch_cnt == 3'd4) desc_b3 <= i_regf_data;
      end
      o_regf_rd_en <= rd_en_d;
      o_regf_addr  <= addr_d;
      o_sdr_en     <= sdr_en_d;
      o_sdr_code   <= sdr_code_d;
      o_ddr_en     <= ddr_en_d;
      o_exit_en    <= exit_en_d;
      o_busy       <= busy_d;
      o_seq_done   <= done_d;
      o_seq_err    <= err_d;
      o_err_code   <= err_next;
    end
  end

  // Next-state logic. In the wait states a done pulse takes priority over an
  // expiring watchdog in the same cycle.
  always_comb begin
    state_next = state;
    err_next   = o_err_code;
    case (state)
      ST_IDLE: begin
        if (i_seq_en) begin
          state_next = ST_FETCH;
          err_next   = ERR_NONE;
        end
      end
      ST_FETCH: begin
        if (fetch_cnt == 3'd4) state_next = ST_DECODE;
      end
      ST_DECODE: begin
        if (desc_mode(desc_b3) == MODE_HDR_DDR) begin
          state_next = ST_SDR;
        end else begin
          state_next = ST_ERR;
          err_next   = ERR_MODE;
        end
      end
      ST_SDR: begin
        if (i_sdr_done) begin
          if (i_sdr_nack) begin
            state_next = ST_ERR;
            err_next   = ERR_NACK;
          end else begin
            state_next = ST_DDR;
          end
        end else if (wd_expired) begin
          state_next = ST_ERR;
          err_next   = ERR_TIMEOUT;
        end
      end
      ST_DDR: begin
        if (i_ddr_done) begin
          state_next = desc_b3[B3_TOC] ? ST_EXIT : ST_DONE;
        end else if (wd_expired) begin
          state_next = ST_ERR;
          err_next   = ERR_TIMEOUT;
        end
      end
      ST_EXIT: begin
        if (i_exit_done) begin
          state_next = ST_DONE;
        end else if (wd_expired) begin
          state_next = ST_ERR;
          err_next   = ERR_TIMEOUT;
        end
      end
      ST_DONE:    state_next = ST_RELEASE;
      ST_ERR:     state_next = ST_RELEASE;
      ST_RELEASE: begin
        // A held request must be dropped before another run can start.
        if (!i_seq_en) state_next = ST_IDLE;
      end
      default:    state_next = ST_IDLE;
    endcase
  end

  // Output decode from the next state, loaded into the output registers.
  always_comb begin
    fetch_cnt_next = 3'd0;
    if (state_next == ST_FETCH && state == ST_FETCH) fetch_cnt_next = fetch_cnt + 3'd1;

    rd_en_d    = 1'b0;
    addr_d     = '0;
    sdr_en_d   = 1'b0;
    sdr_code_d = 8'h00;
    ddr_en_d   = 1'b0;
    exit_en_d  = 1'b0;
    busy_d     = (state_next != ST_IDLE);
    done_d     = (state_next == ST_DONE);
    err_d      = (state_next == ST_ERR);

    // The fifth FETCH cycle only captures byte 3; no read is issued.
    if (state_next == ST_FETCH && fetch_cnt_next < 3'd4) begin
      rd_en_d = 1'b1;
      addr_d  = CONFIG_BASE + {9'd0, fetch_cnt_next};
    end

    case (state_next)
      ST_SDR: begin
        sdr_en_d   = 1'b1;
        sdr_code_d = ENTHDR0;
      end
      ST_DDR:  ddr_en_d  = 1'b1;
      ST_EXIT: exit_en_d = 1'b1;
      default: ;
    endcase
  end

  // CP, WROC, RnW and DTT are latched for visibility only.
  always_comb begin
    o_dbg       = '0;
    o_dbg.state = state;
    o_dbg.cp    = desc_cp;
    o_dbg.toc   = desc_b3[B3_TOC];
    o_dbg.wroc  = desc_b3[B3_WROC];
    o_dbg.rnw   = desc_b3[B3_RNW];
    o_dbg.mode  = desc_b3[B3_MODE_LSB +: 3];
    o_dbg.dtt   = desc_b3[B3_DTT_LSB +: 2];
  end

endmodule
